// File: rtl/x_in_misr_serializer.sv
// x_in_misr_serializer
// Folds a wide input vector into a MISR every enabled cycle. At the end of
// each WINDOW of enabled cycles the signature is snapshotted and shifted out
// MSB first on a single pin as a frame: one start bit, then SIG_WIDTH bits.
module x_in_misr_serializer #(
  parameter int                   NUM_INS   = 8,
  parameter int                   SIG_WIDTH = 16,
  parameter logic [SIG_WIDTH-1:0] POLY      = 16'h1021,
  parameter logic [SIG_WIDTH-1:0] SEED      = '0,
  parameter int                   WINDOW    = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_INS-1:0] in,
  output logic               out,
  output logic               busy,
  output logic               overrun
);

  localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int BW = $clog2(SIG_WIDTH + 1);
  localparam logic [WW-1:0] WLAST = WW'(WINDOW - 1);
  localparam logic [BW-1:0] BLAST = BW'(SIG_WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [SIG_WIDTH-1:0] misr, misr_nxt, fold;
  logic [WW-1:0]        wcnt;
  logic                 snap;

  state_t               state, state_n;
  logic [SIG_WIDTH-1:0] sr, sr_n;
  logic [BW-1:0]        bcnt, bcnt_n;
  logic                 out_n, busy_n, ovr_n;

  // Fold input bit i onto MISR bit (i mod SIG_WIDTH).
  always_comb begin
    fold = '0;
    for (int i = 0; i < NUM_INS; i++)
      fold[i % SIG_WIDTH] = fold[i % SIG_WIDTH] ^ in[i];
  end

  // Next MISR value including this cycle's input; also the snapshot value.
  always_comb begin
    misr_nxt = {misr[SIG_WIDTH-2:0], 1'b0} ^ fold;
    if (misr[SIG_WIDTH-1]) misr_nxt = misr_nxt ^ POLY;
  end

  assign snap = en && (wcnt == WLAST);

  // MISR and window counter: advance on enabled edges, reseed at window end.
  always_ff @(posedge clk) begin
    if (rst) begin
      misr <= SEED;
      wcnt <= '0;
    end else if (en) begin
      if (wcnt == WLAST) begin
        misr <= SEED;
        wcnt <= '0;
      end else begin
        misr <= misr_nxt;
        wcnt <= wcnt + 1'b1;
      end
    end
  end

  // Serializer state register; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sr      <= '0;
      bcnt    <= '0;
      out     <= 1'b0;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state   <= state_n;
      sr      <= sr_n;
      bcnt    <= bcnt_n;
      out     <= out_n;
      busy    <= busy_n;
      overrun <= ovr_n;
    end
  end

  // Serializer next state. bcnt counts data bits already driven; when it
  // reaches SIG_WIDTH the LSB is on the pin and this edge ends the frame,
  // so a snapshot here chains straight into the next frame.
  always_comb begin
    state_n = state;
    sr_n    = sr;
    bcnt_n  = bcnt;
    out_n   = 1'b0;
    busy_n  = busy;
    ovr_n   = overrun;
    case (state)
      IDLE: begin
        busy_n = 1'b0;
        if (snap) begin
          sr_n    = misr_nxt;
          out_n   = 1'b1;
          busy_n  = 1'b1;
          bcnt_n  = '0;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (bcnt == BLAST) begin
          if (snap) begin
            sr_n   = misr_nxt;
            out_n  = 1'b1;
            busy_n = 1'b1;
            bcnt_n = '0;
          end else begin
            busy_n  = 1'b0;
            state_n = IDLE;
          end
        end else begin
          out_n  = sr[SIG_WIDTH-1];
          sr_n   = {sr[SIG_WIDTH-2:0], 1'b0};
          bcnt_n = bcnt + 1'b1;
          busy_n = 1'b1;
          // Frame in flight wins; the late signature is dropped.
          if (snap) ovr_n = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_x_in_misr_serializer.sv
// Directed bench for x_in_misr_serializer: three instances cover the
// WINDOW=16 main configuration, WINDOW=4 overrun and WINDOW=9 back-to-back.
module tb_x_in_misr_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cmp = 0;
  int err = 0;

  // Main instance, WINDOW=16
  logic       rst_a = 1'b1, en_a = 1'b0;
  logic [7:0] in_a = 8'h00;
  logic       out_a, busy_a, ovr_a;
  // Overrun instance, WINDOW=4
  logic       rst_b = 1'b1, en_b = 1'b0;
  logic [7:0] in_b = 8'h00;
  logic       out_b, busy_b, ovr_b;
  // Back-to-back instance, WINDOW=9
  logic       rst_c = 1'b1, en_c = 1'b0;
  logic [7:0] in_c = 8'h00;
  logic       out_c, busy_c, ovr_c;

  x_in_misr_serializer #(.NUM_INS(8), .SIG_WIDTH(8), .POLY(8'h1D), .SEED(8'h00), .WINDOW(16))
    dut_a (.clk(clk), .rst(rst_a), .en(en_a), .in(in_a), .out(out_a), .busy(busy_a), .overrun(ovr_a));
  x_in_misr_serializer #(.NUM_INS(8), .SIG_WIDTH(8), .POLY(8'h1D), .SEED(8'h00), .WINDOW(4))
    dut_b (.clk(clk), .rst(rst_b), .en(en_b), .in(in_b), .out(out_b), .busy(busy_b), .overrun(ovr_b));
  x_in_misr_serializer #(.NUM_INS(8), .SIG_WIDTH(8), .POLY(8'h1D), .SEED(8'h00), .WINDOW(9))
    dut_c (.clk(clk), .rst(rst_c), .en(en_c), .in(in_c), .out(out_c), .busy(busy_c), .overrun(ovr_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called right after the snapshot edge of instance A: start bit is on
  // the pin now; walk the eight data bits MSB first, then the idle edge.
  task automatic frame_a(input string tag, input logic [7:0] sig);
    chk({tag, "_start"}, out_a, 1);
    chk({tag, "_busy0"}, busy_a, 1);
    for (int k = 7; k >= 0; k--) begin
      tick();
      chk($sformatf("%s_bit%0d", tag, k), out_a, sig[k]);
      chk($sformatf("%s_busy_b%0d", tag, k), busy_a, 1);
    end
    tick();
    chk({tag, "_end_out"}, out_a, 0);
    chk({tag, "_end_busy"}, busy_a, 0);
    chk({tag, "_ovr"}, ovr_a, 0);
  endtask

  initial begin
    logic [7:0] sig_b;
    sig_b = 8'h1D;

    // ---- reset state
    tick(); tick();
    chk("rst_out", out_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_ovr", ovr_a, 0);
    rst_a = 1'b0;

    // ---- all-zero stream: signature 00
    en_a = 1'b1; in_a = 8'h00;
    for (int i = 0; i < 15; i++) tick();
    chk("zero_pre_busy", busy_a, 0);
    tick();
    en_a = 1'b0;
    frame_a("zero", 8'h00);

    // ---- single impulse: signature 26
    en_a = 1'b1; in_a = 8'h01;
    tick();
    in_a = 8'h00;
    for (int i = 0; i < 15; i++) tick();
    en_a = 1'b0;
    frame_a("imp", 8'h26);

    // ---- enable gaps with junk input while disabled
    en_a = 1'b1; in_a = 8'h01;
    tick();
    for (int k = 0; k < 15; k++) begin
      if (k == 14) chk("gap_pre_busy", busy_a, 0);
      en_a = 1'b1; in_a = 8'h00;
      tick();
      if (k < 10) begin
        en_a = 1'b0; in_a = 8'hFF;
        tick();
      end
    end
    en_a = 1'b0;
    frame_a("gap", 8'h26);

    // ---- reset mid-frame at the 4th signature bit
    en_a = 1'b1; in_a = 8'h01;
    tick();
    in_a = 8'h00;
    for (int i = 0; i < 15; i++) tick();
    en_a = 1'b0;
    chk("mid_start", out_a, 1);
    tick(); tick(); tick();
    chk("mid_bit5", out_a, 1);  // 26 = 0010_0110, bit5 is third data bit
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    chk("mid_out", out_a, 0);
    chk("mid_busy", busy_a, 0);
    tick();
    chk("mid_out2", out_a, 0);
    en_a = 1'b1; in_a = 8'h01;
    tick();
    in_a = 8'h00;
    for (int i = 0; i < 14; i++) tick();
    chk("post_rst_early", busy_a, 0);
    tick();
    en_a = 1'b0;
    frame_a("post_rst", 8'h26);

    // ---- overrun, WINDOW=4, in=A5 -> signature 1D every window
    rst_b = 1'b0; en_b = 1'b1; in_b = 8'hA5;
    for (int i = 0; i < 4; i++) tick();
    chk("ovr_start", out_b, 1);
    chk("ovr_busy0", busy_b, 1);
    chk("ovr_clear0", ovr_b, 0);
    for (int k = 7; k >= 0; k--) begin
      tick();
      chk($sformatf("ovr_bit%0d", k), out_b, sig_b[k]);
      if (k == 7) chk("ovr_pre", ovr_b, 0);
      if (k == 4) chk("ovr_set", ovr_b, 1);
    end
    tick();
    chk("ovr_end_busy", busy_b, 0);
    chk("ovr_end_out", out_b, 0);
    chk("ovr_sticky1", ovr_b, 1);
    tick(); tick();
    chk("ovr_idle_busy", busy_b, 0);
    tick();
    chk("ovr_restart_out", out_b, 1);
    chk("ovr_restart_busy", busy_b, 1);
    chk("ovr_sticky2", ovr_b, 1);
    tick();
    chk("ovr_restart_msb", out_b, 0);

    // ---- back-to-back, WINDOW=9, in=0 -> frames of 1 then eight 0s
    rst_c = 1'b0; en_c = 1'b1; in_c = 8'h00;
    for (int i = 0; i < 8; i++) tick();
    chk("b2b_pre_busy", busy_c, 0);
    tick();
    chk("b2b_start", out_c, 1);
    for (int k = 1; k <= 27; k++) begin
      tick();
      chk($sformatf("b2b_busy%0d", k), busy_c, 1);
      chk($sformatf("b2b_out%0d", k), out_c, (k % 9 == 0) ? 1 : 0);
    end
    chk("b2b_ovr", ovr_c, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

endmodule

// File: doc/x_in_misr_serializer.md
# x_in_misr_serializer

Downstream companion to the round-robin bit fan-out used for utilization testing. Compresses a NUM_INS-wide input vector every enabled cycle into a multiple-input signature register (MISR). At the end of each fixed window it snapshots the signature and streams it out as a framed serial bit on a single pin. The result is an arbitrarily wide test fabric observed through one output without the synthesizer pruning the logic.

## Interface
- NUM_INS, 8, width of the parallel input vector (>= 1)
- SIG_WIDTH, 16, MISR and signature width (>= 2)
- POLY, 16'h1021, feedback taps (SIG_WIDTH bits; implicit x^SIG_WIDTH term)
- SEED, 0, MISR value after reset and after each window snapshot (SIG_WIDTH bits)
- WINDOW, 256, enabled cycles per signature window (>= 1)

- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- en  input  1  when high, `in` is compressed and the window counter advances
- in  input  NUM_INS  parallel data to compress, sampled on enabled edges
- out  output  1  registered serial frame output; idle level 0
- busy  output  1  high while a frame is on `out` (start bit through last data bit)
- overrun  output  1  sticky; set when a window ends while a frame is still shifting

## Operation
- Fold: fold[j] = XOR of in[i] over all i with i mod SIG_WIDTH == j; bits j >= NUM_INS are 0.
- MISR update on each edge with en=1: misr <= {misr[SIG_WIDTH-2:0],1'b0} ^ (misr[SIG_WIDTH-1] ? POLY : 0) ^ fold. With en=0, misr and the window counter hold.
- Window counter wcnt: 0..WINDOW-1, increments on enabled edges. On the enabled edge with wcnt==WINDOW-1:
  - sig = the MISR next value, including this cycle's input;
  - misr <= SEED; wcnt <= 0.
- Serializer FSM, unaffected by en:
  - IDLE: out=0, busy=0.
  - On the snapshot edge: load shift register with sig, out<=1 (start bit), busy<=1, bit counter <= 0, go to SHIFT.
  - SHIFT: on each of the next SIG_WIDTH edges, out <= next signature bit, MSB first.
  - On the edge after the LSB: out<=0, busy<=0, go to IDLE.
- Frame length: 1 + SIG_WIDTH cycles of busy. A snapshot landing on the same edge that returns to IDLE starts the new frame immediately (back-to-back, no idle gap).
- Overrun: a snapshot while busy and not on the final edge is discarded, and overrun<=1. The frame in flight completes unaltered. The MISR still reloads SEED.
- Reset: misr=SEED, wcnt=0, state IDLE, out=0, busy=0, overrun=0. Reset mid-frame aborts the frame: out=0 on the following cycle.

## Timing
- Input to MISR: 1 cycle (sampled at edge N, reflected in misr after N).
- Snapshot edge E: out=1 (start bit) visible after E. Signature MSB after E+1, LSB after E+SIG_WIDTH. busy falls after E+SIG_WIDTH+1.
- Sustainable without overrun when WINDOW >= SIG_WIDTH+1 with continuous en.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
Configuration unless noted: NUM_INS=8, SIG_WIDTH=8, POLY=8'h1D, SEED=0, WINDOW=16, en=1.
- All-zero stream: in=0 for 16 cycles -> after the 16th edge, out = 1 then eight 0s. busy high for exactly 9 cycles, overrun=0.
- Single impulse: in=8'h01 on cycle 1, then 0 for 15 cycles -> signature 8'h26, so out = 1,0,0,1,0,0,1,1,0.
- Enable gaps: same impulse with en=0 on 10 cycles interleaved after cycle 1 -> identical frame 8'h26, delayed by 10 cycles; `in` values during en=0 are ignored (drive 8'hFF).
- Overrun: WINDOW=4, continuous in=8'hA5 -> first frame completes. Snapshots at +4 and +8 edges are discarded and overrun=1 and stays 1. The next frame starts at the first snapshot after busy drops.
- Back-to-back: WINDOW=9, SIG_WIDTH=8 -> consecutive frames with no idle cycle. busy stays high continuously and overrun stays 0.
- Reset mid-frame: assert rst for 1 cycle at the 4th signature bit -> out=0, busy=0 next cycle. The next window needs a full 16 enabled cycles from SEED.
